// File: rtl/psram_arbiter.sv
// -----------------------------------------------------------------------------
// psram_arbiter
//
// Shares one PSRAM controller user port between two clients: port 0 (HDMI
// framebuffer fetch) and port 1 (general read/write client). One access is in
// flight at a time. An accepted request produces a one-cycle command pulse
// (mem_rd or mem_wr) together with the winner's ack. The sequencer then follows
// mem_busy through its rise and fall and returns a one-cycle done pulse to the
// winner. On reads, mem_dout is captured into that port's rdata on the same
// edge as the done pulse. A timeout covers a controller that never raises
// mem_busy; when it expires it sets the sticky err_timeout flag.
//
// Optional feature macro: PSRAM_ARB_ROUND_ROBIN_EN
//   defined     : simultaneous requests go to the port not granted most
//                 recently (port 0 wins the first tie after reset)
//   not defined : strict priority, port 0 always wins a tie
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   pN_req/we/addr/wdata   (in)  request, held until pN_ack; fields sampled on accept
//   pN_ack                 (out) one-cycle pulse, command issued for port N
//   pN_done                (out) one-cycle pulse, access for port N complete
//   pN_rdata               (out) last read data for port N, valid from its done
//   mem_rd, mem_wr         (out) command pulses to the controller
//   mem_addr, mem_din      (out) address / write data, held between commands
//   mem_dout, mem_busy     (in)  controller read data / busy
//   err_timeout            (out) sticky, set when mem_busy never rose
// -----------------------------------------------------------------------------
module psram_arbiter #(
    parameter int ADDR_W       = 22,
    parameter int DATA_W       = 16,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_busy,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t            r_state, w_state_next;
    logic              r_port, w_port_next;       // latched winner of the current access
    logic              r_we, w_we_next;           // latched direction of the current access
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
    logic [DATA_W-1:0] r_mem_din, w_mem_din_next;
    logic              r_mem_rd, w_mem_rd_next;
    logic              r_mem_wr, w_mem_wr_next;
    logic [1:0]        r_ack, w_ack_next;         // indexed by port
    logic [1:0]        r_done, w_done_next;       // indexed by port
    logic              r_err, w_err_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;

    logic              w_accept;                  // IDLE takes a request this cycle
    logic              w_grant;                   // port that wins if w_accept
    logic              w_capture;                 // read data lands on this edge
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_accept = (r_state == S_IDLE) && (p0_req || p1_req) && !mem_busy;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
    // Port granted most recently; reset value 1 so port 0 wins the first tie.
    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_grant;
        end
    end

    assign w_grant = (p0_req && p1_req) ? ~r_last : p1_req;
`else
    // Port 1 only wins when port 0 is not asking.
    assign w_grant = ~p0_req;
`endif

    assign w_sel_we    = w_grant ? p1_we    : p0_we;
    assign w_sel_addr  = w_grant ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_grant ? p1_wdata : p0_wdata;

    // -------------------------------------------------------------------------
    // Sequencer: next state and next registered outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_port_next     = r_port;
        w_we_next       = r_we;
        w_mem_addr_next = r_mem_addr;
        w_mem_din_next  = r_mem_din;
        w_mem_rd_next   = 1'b0;
        w_mem_wr_next   = 1'b0;
        w_ack_next      = 2'b00;
        w_done_next     = 2'b00;
        w_err_next      = r_err;
        w_cnt_next      = r_cnt;
        w_capture       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // Command and ack are registered so they appear together
                    // for exactly the ISSUE cycle.
                    w_state_next          = S_ISSUE;
                    w_port_next           = w_grant;
                    w_we_next             = w_sel_we;
                    w_mem_addr_next       = w_sel_addr;
                    w_mem_din_next        = w_sel_wdata;
                    w_mem_rd_next         = ~w_sel_we;
                    w_mem_wr_next         = w_sel_we;
                    w_ack_next[w_grant]   = 1'b1;
                end
            end

            S_ISSUE: begin
                w_state_next = S_WAIT_BUSY;
                w_cnt_next   = '0;
            end

            S_WAIT_BUSY: begin
                if (mem_busy) begin
                    w_state_next = S_WAIT_DONE;
                end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    // Count becomes BUSY_TIMEOUT in the cycle done is shown;
                    // rdata is left untouched because nothing was read.
                    w_cnt_next          = CNT_W'(BUSY_TIMEOUT);
                    w_done_next[r_port] = 1'b1;
                    w_err_next          = 1'b1;
                    w_state_next        = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            S_WAIT_DONE: begin
                if (!mem_busy) begin
                    w_done_next[r_port] = 1'b1;
                    w_capture           = ~r_we;
                    w_state_next        = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_port     <= 1'b0;
            r_we       <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_ack      <= 2'b00;
            r_done     <= 2'b00;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_port     <= w_port_next;
            r_we       <= w_we_next;
            r_mem_addr <= w_mem_addr_next;
            r_mem_din  <= w_mem_din_next;
            r_mem_rd   <= w_mem_rd_next;
            r_mem_wr   <= w_mem_wr_next;
            r_ack      <= w_ack_next;
            r_done     <= w_done_next;
            r_err      <= w_err_next;
            r_cnt      <= w_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Per-port read data holding registers
    // -------------------------------------------------------------------------
    logic [1:0][DATA_W-1:0] w_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rdata
            logic [DATA_W-1:0] r_rdata;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata <= '0;
                end else if (w_capture && (r_port == 1'(gi))) begin
                    r_rdata <= mem_dout;
                end
            end

            assign w_rdata[gi] = r_rdata;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign p0_ack      = r_ack[0];
    assign p1_ack      = r_ack[1];
    assign p0_done     = r_done[0];
    assign p1_done     = r_done[1];
    assign p0_rdata    = w_rdata[0];
    assign p1_rdata    = w_rdata[1];
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;
    assign mem_addr    = r_mem_addr;
    assign mem_din     = r_mem_din;
    assign err_timeout = r_err;

endmodule

// File: doc/psram_arbiter.md
# psram_arbiter

Two-port arbiter and sequencer in front of the PSRAM wrapper (`read`/`write`/`addr`/`din`/`dout`/`busy` interface). It shares the single PSRAM controller between the HDMI framebuffer fetch (port 0) and a general read/write client (port 1). It accepts one request at a time and issues a one-cycle command pulse. It then tracks `busy` through its rise and fall and returns a per-port completion with read data. A timeout guards against a controller that never asserts `busy`.

## Interface
- `ADDR_W`, 22: word address width.
- `DATA_W`, 16: data width.
- `BUSY_TIMEOUT`, 8: cycles allowed after the command pulse for `mem_busy` to rise (≥2).
- `clk`  in  1: system clock, same domain as the PSRAM controller user side.
- `rst`  in  1: synchronous, active-high reset.
- `p0_req`, `p1_req`  in  1: request; held high until the matching ack.
- `p0_we`, `p1_we`  in  1: 1 = write, 0 = read; sampled with req.
- `p0_addr`, `p1_addr`  in  ADDR_W: word address.
- `p0_wdata`, `p1_wdata`  in  DATA_W: write data.
- `p0_ack`, `p1_ack`  out  1: one-cycle pulse; request accepted and command issued.
- `p0_done`, `p1_done`  out  1: one-cycle pulse; access complete (reads and writes).
- `p0_rdata`, `p1_rdata`  out  DATA_W: read data; valid on the done pulse of a read, held until that port's next read completes.
- `mem_rd`, `mem_wr`  out  1: command pulses to the controller.
- `mem_addr`  out  ADDR_W: address to the controller.
- `mem_din`  out  DATA_W: write data to the controller.
- `mem_dout`  in  DATA_W: read data from the controller.
- `mem_busy`  in  1: controller busy.
- `err_timeout`  out  1: sticky flag; set when `BUSY_TIMEOUT` expires, cleared only by `rst`.

## Operation
- States:
  - IDLE: accepts requests.
  - ISSUE: drives the command pulse.
  - WAIT_BUSY: waits for `mem_busy` to rise.
  - WAIT_DONE: waits for `mem_busy` to fall.
- IDLE → ISSUE when any req is high and `mem_busy`=0. The winning port is latched, along with its we, addr and wdata.
- ISSUE (1 cycle):
  - Asserts `mem_rd` or `mem_wr` and the winner's ack.
  - Drives `mem_addr` and `mem_din`.
  - Goes to WAIT_BUSY.
- WAIT_BUSY:
  - `mem_busy`=1 → WAIT_DONE.
  - If a cycle counter reaches `BUSY_TIMEOUT` first: set `err_timeout`, pulse the winner's done with rdata unchanged, go to IDLE.
- WAIT_DONE: `mem_busy`=0 → pulse the winner's done; on a read, capture `mem_dout` into that port's rdata in the same edge. Then go to IDLE.
- Arbitration: fixed priority, port 0 wins on a tie (see Configuration).
- Outputs are registered. `mem_rd`, `mem_wr` and acks are never high outside ISSUE. `mem_addr` and `mem_din` hold their last value.
- Reset values:
  - All pulses 0.
  - `mem_addr` and `mem_din` 0.
  - Both rdata 0.
  - `err_timeout` 0.
  - State IDLE.
  - Round-robin pointer favours port 0.
- Reset mid-operation:
  - The in-flight access is abandoned; no done pulse is produced.
  - The arbiter re-enters IDLE.
  - If `mem_busy` is still high it waits, per the IDLE rule.
- A req dropped before ack is legal and simply not served. Changing we, addr or wdata while req is high and unacked is legal; values are sampled on the accept cycle.

## Timing
- Req is seen at edge N in IDLE with `mem_busy`=0. Command and ack are high during cycle N+1 (ISSUE).
- Done is at the edge after `mem_busy` is sampled low in WAIT_DONE.
- Minimum turnaround is done → IDLE (1 cycle) → next ISSUE. Back-to-back accesses are therefore spaced at least 4 cycles plus the controller busy time.
- Timeout: the counter starts at 0 on entry to WAIT_BUSY. Done is issued on the cycle the count equals `BUSY_TIMEOUT` with `mem_busy` still low.
- Done is never asserted in the same cycle as any ack.

## Configuration
- `PSRAM_ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous requests, the port not granted most recently wins.
  - The pointer updates on each ack.
  - After reset, port 0 wins the first tie.
- Not defined: strict priority, port 0 always wins ties. Port 1 may starve under continuous port 0 requests.

## Test plan
- Single read, port 1 at addr 0x00123:
  - Model raises busy 1 cycle after `mem_rd` and holds it 10 cycles with `mem_dout`=0xBEEF.
  - Required: `mem_rd` pulses once with `mem_addr`=0x00123, `p1_ack` in the same cycle, `p1_done` one cycle after busy falls, `p1_rdata`=0xBEEF.
- Single write, port 0 at addr 0x3FFFFF with data 0x1234: `mem_wr` pulses once with `mem_addr`=0x3FFFFF and `mem_din`=0x1234; `p0_done` follows the busy fall; `p0_rdata` unchanged.
- Both ports requesting continuously for 4 accesses:
  - Without the macro: grants are 0,0,0,0.
  - With the macro: grants are 0,1,0,1.
- Controller never raises busy, `BUSY_TIMEOUT`=8: done pulses exactly 8 cycles after entering WAIT_BUSY; `err_timeout`=1 and stays set until `rst`.
- `rst` asserted during WAIT_DONE: no done pulse; all outputs return to reset values; the next request is only issued after `mem_busy`=0.
- Request present while `mem_busy` is held high externally: no ack until `mem_busy` falls; ack then occurs 1 cycle later.
